conversor_binario_bcd: RTL and testbench
========================================

// Module: conversor_binario_bcd
//
// PURPOSE
// Iterative binary-to-BCD converter (shift-add-3 / double dabble). Sits directly
// upstream of the seven-segment decoder stage. It accepts an unsigned binary value
// over a valid/ready handshake and produces DIGITOS packed BCD digits. Each 4-bit
// slice feeds one decoder instance's digito_bcd input.
//
// PARAMETERS
// LARGURA_BIN  8  width of the binary input, >= 1
// DIGITOS      3  number of BCD output digits, >= 1
//
// PORTS
// clk             input   1              rising-edge clock
// rst_n           input   1              asynchronous active-low reset
// entrada_valida  input   1              valor_bin is valid
// entrada_pronta  output  1              converter can accept a value
// valor_bin       input   LARGURA_BIN    unsigned binary value
// saida_valida    output  1              digitos_bcd / estouro are valid
// saida_pronta    input   1              consumer accepts the result
// digitos_bcd     output  4*DIGITOS      BCD digits; [3:0] = units, [7:4] = tens, ...
// estouro         output  1              value >= 10**DIGITOS; digits hold value mod 10**DIGITOS
//
// BEHAVIOUR
// - Clocking and reset: one clock, clk. rst_n is asynchronous and active-low; its
//   release is synchronous to clk.
// - Reset values: state = OCIOSO, entrada_pronta = 1, saida_valida = 0,
//   digitos_bcd = 0, estouro = 0, shift counter = 0.
// - Reset mid-conversion or with a result pending: the operation is aborted and the
//   result is discarded. No output pulse occurs.
// - FSM:
//   - OCIOSO: entrada_pronta = 1. On entrada_valida, capture valor_bin into the shift
//     register, clear the BCD accumulator and estouro, load the counter with
//     LARGURA_BIN, then go to DESLOCA.
//   - DESLOCA: entrada_pronta = 0, one input bit per cycle:
//     - every nibble >= 5 gets +3;
//     - then {bcd, bin} shifts left by 1;
//     - the bit shifted out of the top nibble is ORed into estouro;
//     - the counter decrements. When the counter reaches 1, go to PRONTO.
//   - PRONTO: saida_valida = 1 and the outputs are stable. When saida_pronta = 1, go
//     to OCIOSO. A new input is not accepted in the same cycle.
// - Latency: handshake in cycle T; saida_valida asserted in cycle T+LARGURA_BIN+1.
//   Maximum throughput is one conversion per LARGURA_BIN+2 cycles.
// - Backpressure: while saida_valida = 1 and saida_pronta = 0, digitos_bcd and
//   estouro hold unchanged for any number of cycles.
// - Input side: valor_bin is sampled only at the accepting edge. Changes to valor_bin
//   after that edge have no effect.
// - Arithmetic:
//   - All nibbles stay in the range 0..9 after every shift.
//   - Truncation to DIGITOS digits yields value mod 10**DIGITOS.
//   - estouro = 1 exactly when value >= 10**DIGITOS.
// - Boundaries:
//   - value 0 gives all-zero digits.
//   - value 2**LARGURA_BIN-1 gives the full conversion.
//   - LARGURA_BIN = 1 gives a single DESLOCA cycle.
// - digitos_bcd is undefined-free: outside PRONTO it holds the last result, or 0
//   after reset.
//
// CONFIGURATION
// - APAGA_ZEROS_EN defined: leading-zero blanking on the registered result when
//   entering PRONTO.
//   - Scanning from the most significant digit down, each leading 4'h0 is replaced
//     by 4'hF. The downstream decoder's default case then drives all segments off.
//   - Digit 0 (units) is never blanked. Once a non-zero digit is found, no lower
//     digit is blanked.
//   - estouro is unaffected.
// - APAGA_ZEROS_EN undefined: digits are output exactly as converted. No 4'hF is ever
//   produced.
//
// TESTING
// - Defaults, valor_bin = 255, saida_pronta = 1 -> after 9 cycles saida_valida = 1,
//   digitos_bcd = 12'h255, estouro = 0.
// - valor_bin = 0 -> digitos_bcd = 12'h000; with APAGA_ZEROS_EN -> 12'hFF0.
//   valor_bin = 7 with APAGA_ZEROS_EN -> 12'hFF7.
// - DIGITOS = 2, valor_bin = 200 -> digitos_bcd = 8'h00, estouro = 1.
//   valor_bin = 99 -> 8'h99, estouro = 0.
// - valor_bin = 128, saida_pronta held at 0 for 20 cycles -> saida_valida = 1 and
//   12'h128 held throughout; entrada_pronta = 0 until 1 cycle after saida_pronta = 1.
// - entrada_valida held high at 10 then 20 back-to-back -> accepts spaced 10 cycles
//   apart (LARGURA_BIN+2), results 12'h010 then 12'h020. valor_bin changed during
//   DESLOCA has no effect.
// - rst_n pulsed low in the 4th DESLOCA cycle -> outputs and entrada_pronta return to
//   reset values asynchronously; no saida_valida. The next input of 42 gives 12'h042.

Source files
------------

// File: rtl/conversor_binario_bcd.sv
// Iterative binary-to-BCD converter (shift-add-3) with a valid/ready handshake on both sides.
// Optional leading-zero blanking of the result is enabled with `define APAGA_ZEROS_EN.
module conversor_binario_bcd #(
  parameter int LARGURA_BIN = 8,
  parameter int DIGITOS     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     entrada_valida,
  output logic                     entrada_pronta,
  input  logic [LARGURA_BIN-1:0]   valor_bin,
  output logic                     saida_valida,
  input  logic                     saida_pronta,
  output logic [4*DIGITOS-1:0]     digitos_bcd,
  output logic                     estouro
);

  // state   | meaning
  // OCIOSO  | waiting for entrada_valida; entrada_pronta = 1
  // DESLOCA | one add-3/shift step per cycle, counter runs down to 1
  // PRONTO  | result registered and held until saida_pronta

  localparam int CW = $clog2(LARGURA_BIN + 1);
  localparam int BW = 4 * DIGITOS;

  typedef enum logic [1:0] {OCIOSO, DESLOCA, PRONTO} estado_t;

  estado_t                estado;
  logic [LARGURA_BIN-1:0] bin_sr;
  logic [BW-1:0]          bcd_acc;
  logic [BW-1:0]          bcd_adj;
  logic [BW-1:0]          bcd_shift;
  logic [BW-1:0]          bcd_final;
  logic [CW-1:0]          contador;
  logic                   estouro_acc;
  logic                   transbordo;

  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < DIGITOS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end
  end

  // The bit leaving the top nibble can only be set when the value needs more digits.
  assign bcd_shift  = {bcd_adj[BW-2:0], bin_sr[LARGURA_BIN-1]};
  assign transbordo = bcd_adj[BW-1];

`ifdef APAGA_ZEROS_EN
  logic achou;

  always_comb begin
    bcd_final = bcd_shift;
    achou     = 1'b0;
    for (int i = DIGITOS - 1; i >= 1; i--) begin
      if (!achou && bcd_shift[4*i +: 4] == 4'h0)
        bcd_final[4*i +: 4] = 4'hF;
      else
        achou = 1'b1;
    end
  end
`else
  assign bcd_final = bcd_shift;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado         <= OCIOSO;
      entrada_pronta <= 1'b1;
      saida_valida   <= 1'b0;
      digitos_bcd    <= '0;
      estouro        <= 1'b0;
      contador       <= '0;
      bin_sr         <= '0;
      bcd_acc        <= '0;
      estouro_acc    <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (entrada_valida) begin
            bin_sr         <= valor_bin;
            bcd_acc        <= '0;
            estouro_acc    <= 1'b0;
            estouro        <= 1'b0;
            contador       <= CW'(LARGURA_BIN);
            entrada_pronta <= 1'b0;
            estado         <= DESLOCA;
          end
        end
        DESLOCA: begin
          bcd_acc     <= bcd_shift;
          bin_sr      <= bin_sr << 1;
          estouro_acc <= estouro_acc | transbordo;
          contador    <= contador - CW'(1);
          if (contador == CW'(1)) begin
            digitos_bcd  <= bcd_final;
            estouro      <= estouro_acc | transbordo;
            saida_valida <= 1'b1;
            estado       <= PRONTO;
          end
        end
        PRONTO: begin
          // No new input in the release cycle: entrada_pronta rises one cycle later.
          if (saida_pronta) begin
            saida_valida   <= 1'b0;
            entrada_pronta <= 1'b1;
            estado         <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_binario_bcd.sv
// Self-checking bench for conversor_binario_bcd: latency/handshake model plus directed literal checks.
// Three instances: defaults (8 bits, 3 digits), 2 digits, and 1 bit / 1 digit.
module tb_conversor_binario_bcd;

`ifdef APAGA_ZEROS_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ev, ep, sv, sp, est;
  logic [7:0]  vb;
  logic [11:0] dig;
  logic        ev2, ep2, sv2, sp2, est2;
  logic [7:0]  vb2, dig2;
  logic        ev3, ep3, sv3, sp3, est3;
  logic [0:0]  vb3;
  logic [3:0]  dig3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conversor_binario_bcd dut (
    .clk(clk), .rst_n(rst_n), .entrada_valida(ev), .entrada_pronta(ep), .valor_bin(vb),
    .saida_valida(sv), .saida_pronta(sp), .digitos_bcd(dig), .estouro(est));

  conversor_binario_bcd #(.LARGURA_BIN(8), .DIGITOS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .entrada_valida(ev2), .entrada_pronta(ep2), .valor_bin(vb2),
    .saida_valida(sv2), .saida_pronta(sp2), .digitos_bcd(dig2), .estouro(est2));

  conversor_binario_bcd #(.LARGURA_BIN(1), .DIGITOS(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .entrada_valida(ev3), .entrada_pronta(ep3), .valor_bin(vb3),
    .saida_valida(sv3), .saida_pronta(sp3), .digitos_bcd(dig3), .estouro(est3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Decimal digits of v, truncated to d digits, optionally blanked from the top.
  function automatic logic [31:0] exp_bcd(input int v, input int d);
    logic [31:0] r;
    int x;
    bit seen;
    r = '0;
    x = v;
    seen = 1'b0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    if (BLK) begin
      for (int i = d - 1; i >= 1; i--) begin
        if (!seen && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
        else seen = 1'b1;
      end
    end
    return r;
  endfunction

  // ph: 0 idle, 1 converting (wt cycles left), 2 result pending
  typedef struct {
    int          ph;
    int          wt;
    int          val;
    logic [31:0] d;
    logic        e;
  } mdl_t;

  function automatic mdl_t mzero();
    mdl_t r;
    r.ph = 0; r.wt = 0; r.val = 0; r.d = '0; r.e = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic evi, input logic spi,
                                 input int v, input int l, input int d);
    mdl_t r;
    r = m;
    case (m.ph)
      0: if (evi) begin r.val = v; r.wt = l; r.ph = 1; end
      1: begin
        r.wt = m.wt - 1;
        if (r.wt == 0) begin
          r.d  = exp_bcd(m.val, d);
          r.e  = (m.val >= 10**d);
          r.ph = 2;
        end
      end
      default: if (spi) r.ph = 0;
    endcase
    return r;
  endfunction

  mdl_t m1, m2, m3;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= mzero(); m2 <= mzero(); m3 <= mzero();
    end else begin
      m1 <= mstep(m1, ev,  sp,  int'(vb),  8, 3);
      m2 <= mstep(m2, ev2, sp2, int'(vb2), 8, 2);
      m3 <= mstep(m3, ev3, sp3, int'(vb3), 1, 1);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready1", 32'(ep), 32'(m1.ph == 0));
      chk("valid1", 32'(sv), 32'(m1.ph == 2));
      chk("digits1", 32'(dig), m1.d);
      if (m1.ph == 2) chk("estouro1", 32'(est), 32'(m1.e));
      chk("ready2", 32'(ep2), 32'(m2.ph == 0));
      chk("valid2", 32'(sv2), 32'(m2.ph == 2));
      chk("digits2", 32'(dig2), m2.d);
      if (m2.ph == 2) chk("estouro2", 32'(est2), 32'(m2.e));
      chk("ready3", 32'(ep3), 32'(m3.ph == 0));
      chk("valid3", 32'(sv3), 32'(m3.ph == 2));
      chk("digits3", 32'(dig3), m3.d);
      if (m3.ph == 2) chk("estouro3", 32'(est3), 32'(m3.e));
    end
  end

  int          cyc = 0;
  int          acc_cyc[$];
  logic [11:0] res_q[$];

  always @(posedge clk) begin
    if (rst_n && ev && ep) acc_cyc.push_back(cyc);
    if (rst_n && sv && sp) res_q.push_back(dig);
    cyc <= cyc + 1;
  end

  task automatic xfer1(input logic [7:0] v, input logic [11:0] exp_d, input logic exp_e,
                       input int hold, input string nm);
    int k;
    @(posedge clk); #1;
    ev = 1'b1; vb = v; sp = 1'b0;
    @(posedge clk); #1;
    ev = 1'b0; vb = ~v;
    k = 1;
    while (!sv && k < 50) begin @(posedge clk); #1; k++; end
    chk({nm, " latency"}, 32'(k), 32'd9);
    chk({nm, " digits"}, 32'(dig), 32'(exp_d));
    chk({nm, " estouro"}, 32'(est), 32'(exp_e));
    repeat (hold) begin @(posedge clk); #1; end
    if (hold > 0) begin
      chk({nm, " held digits"}, 32'(dig), 32'(exp_d));
      chk({nm, " held valid"}, 32'(sv), 32'd1);
      chk({nm, " held not ready"}, 32'(ep), 32'd0);
    end
    sp = 1'b1;
    @(posedge clk); #1;
    sp = 1'b0;
    chk({nm, " ready after"}, 32'(ep), 32'd1);
    chk({nm, " valid after"}, 32'(sv), 32'd0);
  endtask

  task automatic xs(input int w, input int v, input logic [7:0] exp_d, input logic exp_e,
                    input int exp_lat, input string nm);
    int k;
    logic s;
    @(posedge clk); #1;
    if (w == 2) begin ev2 = 1'b1; vb2 = 8'(v); end
    else begin ev3 = 1'b1; vb3 = 1'(v); end
    @(posedge clk); #1;
    ev2 = 1'b0; ev3 = 1'b0;
    k = 1;
    s = (w == 2) ? sv2 : sv3;
    while (!s && k < 50) begin
      @(posedge clk); #1; k++;
      s = (w == 2) ? sv2 : sv3;
    end
    chk({nm, " latency"}, 32'(k), 32'(exp_lat));
    chk({nm, " digits"}, (w == 2) ? 32'(dig2) : 32'(dig3), 32'(exp_d));
    chk({nm, " estouro"}, (w == 2) ? 32'(est2) : 32'(est3), 32'(exp_e));
    @(posedge clk); #1;
  endtask

  initial begin
    int k, n0, r0, nsv;
    rst_n = 1'b0;
    ev = 1'b0; vb = '0; sp = 1'b0;
    ev2 = 1'b0; vb2 = '0; sp2 = 1'b1;
    ev3 = 1'b0; vb3 = '0; sp3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 32'(ep), 32'd1);
    chk("reset valid", 32'(sv), 32'd0);
    chk("reset digits", 32'(dig), 32'd0);
    chk("reset estouro", 32'(est), 32'd0);
    rst_n = 1'b1;

    xfer1(8'd255, 12'h255, 1'b0, 0, "v255");
    xfer1(8'd0, BLK ? 12'hFF0 : 12'h000, 1'b0, 0, "v0");
    xfer1(8'd7, BLK ? 12'hFF7 : 12'h007, 1'b0, 0, "v7");
    xfer1(8'd128, 12'h128, 1'b0, 20, "v128 hold");

    // back-to-back with entrada_valida held high
    @(posedge clk); #1;
    n0 = acc_cyc.size();
    r0 = res_q.size();
    ev = 1'b1; vb = 8'd10; sp = 1'b1;
    k = 0;
    while (acc_cyc.size() == n0 && k < 20) begin @(posedge clk); #1; k++; end
    vb = 8'd20;
    while (acc_cyc.size() < n0 + 2 && k < 40) begin @(posedge clk); #1; k++; end
    ev = 1'b0; vb = 8'd99;
    while (res_q.size() < r0 + 2 && k < 60) begin @(posedge clk); #1; k++; end
    chk("b2b accepts", 32'(acc_cyc.size() - n0), 32'd2);
    if (acc_cyc.size() >= n0 + 2)
      chk("b2b spacing", 32'(acc_cyc[n0+1] - acc_cyc[n0]), 32'd10);
    chk("b2b results", 32'(res_q.size() - r0), 32'd2);
    if (res_q.size() >= r0 + 2) begin
      chk("b2b first", 32'(res_q[r0]), BLK ? 32'hF10 : 32'h010);
      chk("b2b second", 32'(res_q[r0+1]), BLK ? 32'hF20 : 32'h020);
    end
    @(posedge clk); #1;
    sp = 1'b0;

    // reset in the 4th DESLOCA cycle
    @(posedge clk); #1;
    ev = 1'b1; vb = 8'd200;
    @(posedge clk); #1;
    ev = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    r0 = res_q.size();
    rst_n = 1'b0;
    #1;
    chk("midreset ready", 32'(ep), 32'd1);
    chk("midreset valid", 32'(sv), 32'd0);
    chk("midreset digits", 32'(dig), 32'd0);
    chk("midreset estouro", 32'(est), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sp = 1'b1;
    nsv = 0;
    repeat (12) begin @(posedge clk); #1; if (sv) nsv++; end
    chk("midreset no valid", 32'(nsv), 32'd0);
    chk("midreset no result", 32'(res_q.size() - r0), 32'd0);
    xfer1(8'd42, BLK ? 12'hF42 : 12'h042, 1'b0, 0, "v42");

    xs(2, 200, BLK ? 8'hF0 : 8'h00, 1'b1, 9, "d2 v200");
    xs(2, 99, 8'h99, 1'b0, 9, "d2 v99");
    xs(2, 100, BLK ? 8'hF0 : 8'h00, 1'b1, 9, "d2 v100");
    xs(3, 1, 8'h1, 1'b0, 2, "w1 v1");
    xs(3, 0, 8'h0, 1'b0, 2, "w1 v0");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
